// File: rtl/mpu_matrix_loader.sv
// mpu_matrix_loader: streams 50 bytes into two 5x5 byte matrices (A then B),
// presents them together, and waits for downstream to acknowledge the pair.
// Element (i,j) lives at bits 8*(i+5*j) +: 8 of each 200-bit bus.
// Optional macro MPU_LOAD_TRANSPOSE_EN stores matrix B transposed.
module mpu_matrix_loader (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [199:0] matrix_a,
  output logic [199:0] matrix_b,
  output logic         matrices_valid,
  input  logic         matrices_ack,
  output logic         busy,
  output logic [5:0]   elem_count
);

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, DONE} state_t;

  state_t         state_reg, state_next;
  logic [5:0]     count_reg, count_next;
  logic [199:0]   mat_a_reg, mat_a_next;
  logic [199:0]   mat_b_reg, mat_b_next;
  logic           xfer;
  logic           wr_a;
  logic           wr_b;

  // Ready is decoded from state only, so no path exists from in_valid.
  assign in_ready       = (state_reg == LOAD_A) || (state_reg == LOAD_B);
  assign xfer           = in_valid && in_ready;
  assign wr_a           = xfer && (state_reg == LOAD_A);
  assign wr_b           = xfer && (state_reg == LOAD_B);
  assign matrices_valid = (state_reg == DONE);
  assign busy           = (state_reg != IDLE);
  assign elem_count     = count_reg;
  assign matrix_a       = mat_a_reg;
  assign matrix_b       = mat_b_reg;

  // Per-element write decode: each byte slot knows which stream index feeds it.
  // A uses the running count directly; B is offset by the 25 A elements.
  generate
    for (genvar gi = 0; gi < 25; gi++) begin : g_elem
`ifdef MPU_LOAD_TRANSPOSE_EN
      // Slot p = j+5*i receives B element k = i+5*j, i.e. k = p/5 + 5*(p%5).
      localparam int B_SRC = (gi / 5) + 5 * (gi % 5);
`else
      localparam int B_SRC = gi;
`endif
      localparam logic [5:0] A_IDX = 6'(gi);
      localparam logic [5:0] B_IDX = 6'(B_SRC + 25);

      assign mat_a_next[8*gi +: 8] = (wr_a && (count_reg == A_IDX)) ?
                                     in_data : mat_a_reg[8*gi +: 8];
      assign mat_b_next[8*gi +: 8] = (wr_b && (count_reg == B_IDX)) ?
                                     in_data : mat_b_reg[8*gi +: 8];
    end
  endgenerate

  // Next-state, element counter and phase changes.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD_A;
          count_next = 6'd0;
        end
      end
      LOAD_A: begin
        if (xfer) begin
          count_next = count_reg + 6'd1;
          if (count_reg == 6'd24) state_next = LOAD_B;
        end
      end
      LOAD_B: begin
        if (xfer) begin
          count_next = count_reg + 6'd1;
          if (count_reg == 6'd49) state_next = DONE;
        end
      end
      DONE: begin
        if (matrices_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter and matrix storage; reset discards any pair in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= 6'd0;
      mat_a_reg <= '0;
      mat_b_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      mat_a_reg <= mat_a_next;
      mat_b_reg <= mat_b_next;
    end
  end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Testbench for mpu_matrix_loader: table of load patterns plus hand-written
// reset/ignored-control sequences; expected matrix pairs go through a queue.
module tb_mpu_matrix_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [199:0] matrix_a;
  logic [199:0] matrix_b;
  logic         matrices_valid;
  logic         matrices_ack;
  logic         busy;
  logic [5:0]   elem_count;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int         a_base;
    int         a_step;
    int         b_base;
    int         b_step;
    bit         stall;
    bit         poke_start;
    bit         ack_start;
    logic [7:0] exp_a0;
    logic [7:0] exp_a24;
    logic [7:0] exp_b0;
  } vec_t;

  typedef struct {
    logic [199:0] a;
    logic [199:0] b;
  } pair_t;

  pair_t        sb_q[$];
  logic [199:0] prev_a;
  logic [199:0] prev_b;
  vec_t         vecs[4];

  mpu_matrix_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .matrix_a(matrix_a),
    .matrix_b(matrix_b), .matrices_valid(matrices_valid),
    .matrices_ack(matrices_ack), .busy(busy), .elem_count(elem_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] elem_val(input vec_t v, input int n);
    int x;
    if (n < 25) x = v.a_base + v.a_step * n;
    else        x = v.b_base + v.b_step * (n - 25);
    return 8'(x);
  endfunction

  // Reference placement: A row-major by stream index, B optionally transposed.
  function automatic pair_t build_pair(input vec_t v);
    pair_t p;
    int    pos;
    p.a = '0;
    p.b = '0;
    for (int k = 0; k < 25; k++) begin
      p.a[8*k +: 8] = elem_val(v, k);
`ifdef MPU_LOAD_TRANSPOSE_EN
      pos = (k / 5) + 5 * (k % 5);
`else
      pos = k;
`endif
      p.b[8*pos +: 8] = elem_val(v, k + 25);
    end
    return p;
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 200'(busy), 200'(1));
    check("start_ready", 200'(in_ready), 200'(1));
    check("start_count", 200'(elem_count), 200'(0));
    check("start_keep_a", matrix_a, prev_a);
    check("start_keep_b", matrix_b, prev_b);
  endtask

  // Full load of one table entry, then DONE hold and acknowledge.
  task automatic run_load(input vec_t v, input int idx);
    pair_t exp;
    pair_t got;
    exp = build_pair(v);
    sb_q.push_back(exp);
    do_start();
    for (int n = 0; n < 50; n++) begin
      if (v.stall) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
        check("stall_count", 200'(elem_count), 200'(n));
        check("stall_ready", 200'(in_ready), 200'(1));
      end
      check("pre_valid", 200'(matrices_valid), 200'(0));
      in_valid = 1'b1;
      in_data  = elem_val(v, n);
      if (v.poke_start && n == 7) start = 1'b1;
      tick();
      start = 1'b0;
      check("xfer_count", 200'(elem_count), 200'(n + 1));
      check("xfer_ready", 200'(in_ready), 200'(n < 49 ? 1 : 0));
    end
    in_valid = 1'b1;
    in_data  = 8'hA5;
    check("done_valid", 200'(matrices_valid), 200'(1));
    if (sb_q.size() == 0) begin
      check("sb_empty", 200'(0), 200'(1));
      got = exp;
    end else begin
      got = sb_q.pop_front();
    end
    check("pair_a", matrix_a, got.a);
    check("pair_b", matrix_b, got.b);
    check("byte_a0", 200'(matrix_a[7:0]), 200'(v.exp_a0));
    check("byte_a24", 200'(matrix_a[199:192]), 200'(v.exp_a24));
    check("byte_b0", 200'(matrix_b[7:0]), 200'(v.exp_b0));
    for (int c = 0; c < 10; c++) begin
      tick();
      check("hold_valid", 200'(matrices_valid), 200'(1));
      check("hold_ready", 200'(in_ready), 200'(0));
      check("hold_count", 200'(elem_count), 200'(50));
      check("hold_a", matrix_a, got.a);
      check("hold_b", matrix_b, got.b);
    end
    in_valid = 1'b0;
    matrices_ack = 1'b1;
    if (v.ack_start) start = 1'b1;
    tick();
    matrices_ack = 1'b0;
    start = 1'b0;
    check("ack_busy", 200'(busy), 200'(0));
    check("ack_valid", 200'(matrices_valid), 200'(0));
    for (int c = 0; c < 3; c++) begin
      tick();
      check("idle_busy", 200'(busy), 200'(0));
      check("idle_ready", 200'(in_ready), 200'(0));
    end
    prev_a = got.a;
    prev_b = got.b;
    $display("load %0d stall=%0d a0=%0h b0=%0h done", idx, v.stall, matrix_a[7:0], matrix_b[7:0]);
  endtask

  initial begin
    vecs[0] = '{1,   1, 25,  -1, 1'b0, 1'b0, 1'b0, 8'd1,   8'd25, 8'd25};
    vecs[1] = '{1,   1, 25,  -1, 1'b1, 1'b1, 1'b0, 8'd1,   8'd25, 8'd25};
    vecs[2] = '{0,   1, 0,    1, 1'b0, 1'b0, 1'b1, 8'd0,   8'd24, 8'd0};
    vecs[3] = '{200, 3, 255, -7, 1'b1, 1'b0, 1'b1, 8'd200, 8'd16, 8'd255};

    rst_n = 1'b0; start = 1'b0; in_data = 8'h00; in_valid = 1'b1; matrices_ack = 1'b0;
    prev_a = '0; prev_b = '0;
    tick();
    tick();
    check("rst_busy", 200'(busy), 200'(0));
    check("rst_ready", 200'(in_ready), 200'(0));
    check("rst_valid", 200'(matrices_valid), 200'(0));
    check("rst_count", 200'(elem_count), 200'(0));
    check("rst_a", matrix_a, 200'(0));
    check("rst_b", matrix_b, 200'(0));
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
    check("idle_no_start", 200'(busy), 200'(0));

    for (int i = 0; i < 4; i++) run_load(vecs[i], i);

    // Reset with 30 elements accepted discards the pair.
    do_start();
    for (int n = 0; n < 30; n++) begin
      in_valid = 1'b1;
      in_data  = 8'(n + 100);
      tick();
    end
    in_valid = 1'b0;
    check("mid_count", 200'(elem_count), 200'(30));
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hFF;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    check("mrst_busy", 200'(busy), 200'(0));
    check("mrst_ready", 200'(in_ready), 200'(0));
    check("mrst_valid", 200'(matrices_valid), 200'(0));
    check("mrst_count", 200'(elem_count), 200'(0));
    check("mrst_a", matrix_a, 200'(0));
    check("mrst_b", matrix_b, 200'(0));
    $display("mid-load reset at 30 elements done");
    prev_a = '0;
    prev_b = '0;
    run_load(vecs[0], 4);

    check("sb_drained", 200'(sb_q.size()), 200'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
